// File: rtl/reg_writeback_queue.sv
// Writeback queue in front of the register file's single write port.
// Buffers rd/data pairs in FIFO order and forwards the youngest pending value to two lookup ports.
module reg_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int AW    = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AW-1:0]          in_rd,
  input  logic [XLEN-1:0]        in_data,
  input  logic                   hold,
  output logic                   rf_we,
  output logic [AW-1:0]          rf_addr,
  output logic [XLEN-1:0]        rf_wdata,
  input  logic [AW-1:0]          q1_addr,
  output logic                   q1_hit,
  output logic [XLEN-1:0]        q1_data,
  input  logic [AW-1:0]          q2_addr,
  output logic                   q2_hit,
  output logic [XLEN-1:0]        q2_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic            hit;
    logic [XLEN-1:0] data;
  } lookup_t;

  logic [AW-1:0]   rd_q    [DEPTH];
  logic [XLEN-1:0] data_q  [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;

  logic push;
  logic enq;
  logic pop;

  // Status and handshake depend on registered state only, so a full queue never accepts
  // even when it is draining in the same cycle.
  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign in_ready = !full;

  // Writes to x0 complete the handshake but are never stored.
  assign push = in_valid && in_ready;
  assign enq  = push && (in_rd != '0);

  assign rf_we    = !empty && !hold;
  assign pop      = rf_we;
  assign rf_addr  = empty ? '0 : rd_q[head];
  assign rf_wdata = empty ? '0 : data_q[head];

  always_ff @(posedge clk) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      valid_q <= '0;
    end else begin
      // NOTE: enq and pop never touch the same slot: enq needs !full, and with head==tail
      // a nonempty queue is full, so both updates can sit side by side here.
      if (enq) begin
        valid_q[tail] <= 1'b1;
        tail          <= tail + 1'b1;
      end
      if (pop) begin
        valid_q[head] <= 1'b0;
        head          <= head + 1'b1;
      end
      unique case ({enq, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the payload array is deliberately left out of reset; valid_q and the empty mux
  // keep stale contents from ever reaching an output.
  always_ff @(posedge clk) begin
    if (enq) begin
      rd_q[tail]   <= in_rd;
      data_q[tail] <= in_data;
    end
  end

  // Scans from head (oldest) to tail (youngest); later matches overwrite earlier ones.
  function automatic lookup_t lookup(input logic [AW-1:0] addr);
    lookup_t       r;
    logic [PW-1:0] idx;
    r.hit  = 1'b0;
    r.data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (valid_q[idx] && (rd_q[idx] == addr) && (addr != '0)) begin
        r.hit  = 1'b1;
        r.data = data_q[idx];
      end
    end
    return r;
  endfunction

  lookup_t l1;
  lookup_t l2;

  always_comb begin
    l1 = lookup(q1_addr);
    l2 = lookup(q2_addr);
  end

  assign q1_hit  = l1.hit;
  assign q1_data = l1.data;
  assign q2_hit  = l2.hit;
  assign q2_data = l2.data;

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed bench for reg_writeback_queue: a per-cycle vector table plus model-checked
// sequences for pointer wrap and simultaneous push/pop.
module tb_reg_writeback_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_data;
  logic        hold;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wdata;
  logic [4:0]  q1_addr;
  logic        q1_hit;
  logic [31:0] q1_data;
  logic [4:0]  q2_addr;
  logic        q2_hit;
  logic [31:0] q2_data;
  logic [2:0]  count;
  logic        empty;
  logic        full;

  int n_vec = 0;
  int n_err = 0;

  reg_writeback_queue #(.DEPTH(4), .XLEN(32), .AW(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_data(in_data),
    .hold(hold),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
    .q1_addr(q1_addr), .q1_hit(q1_hit), .q1_data(q1_data),
    .q2_addr(q2_addr), .q2_hit(q2_hit), .q2_data(q2_data),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        v;
    logic [4:0]  rd;
    logic [31:0] d;
    logic        hold;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [109:0] exp;
  } vec_t;

  // Expected output vector in the same order as outs() below.
  function automatic logic [109:0] ex(input logic rdy, input logic we, input logic [31:0] addr,
                                      input logic [31:0] wd, input logic h1, input logic [31:0] d1,
                                      input logic h2, input logic [31:0] d2, input logic [31:0] cnt,
                                      input logic emp, input logic fl);
    return {rdy, we, addr[4:0], wd, h1, d1, h2, d2, cnt[2:0], emp, fl};
  endfunction

  function automatic vec_t mk(input logic r, input logic v, input logic [31:0] rd,
                              input logic [31:0] d, input logic h, input logic [31:0] a1,
                              input logic [31:0] a2, input logic [109:0] e);
    vec_t t;
    t.rst = r; t.v = v; t.rd = rd[4:0]; t.d = d; t.hold = h;
    t.a1 = a1[4:0]; t.a2 = a2[4:0]; t.exp = e;
    return t;
  endfunction

  function automatic logic [109:0] outs();
    return {in_ready, rf_we, rf_addr, rf_wdata, q1_hit, q1_data, q2_hit, q2_data, count, empty, full};
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Reference queue of {rd, data} for the sequence tests.
  logic [36:0] model[$];

  task automatic cyc(input logic v, input logic [4:0] rd, input logic [31:0] d, input logic h);
    logic        exp_we;
    logic        accept;
    logic [36:0] front;
    in_valid = v; in_rd = rd; in_data = d; hold = h; q1_addr = '0; q2_addr = '0;
    #1;
    exp_we = (model.size() > 0) && !h;
    accept = v && (model.size() < 4);
    front  = (model.size() > 0) ? model[0] : '0;
    check("seq_we", 128'(rf_we), 128'(exp_we));
    check("seq_wr", 128'({rf_addr, rf_wdata}), 128'(front));
    check("seq_count", 128'(count), 128'(model.size()));
    check("seq_ready", 128'(in_ready), 128'(model.size() < 4));
    @(posedge clk);
    #1;
    if (exp_we) void'(model.pop_front());
    if (accept && rd != '0) model.push_back({rd, d});
  endtask

  vec_t vecs[23];

  initial begin
    // Single write, then x0 drop.
    vecs[0]  = mk(0,0,0,0,0,0,0,          ex(1,0,0,0,0,0,0,0,0,1,0));
    vecs[1]  = mk(0,1,5,32'hDEADBEEF,0,5,0,ex(1,0,0,0,0,0,0,0,0,1,0));
    vecs[2]  = mk(0,0,0,0,0,5,0,          ex(1,1,5,32'hDEADBEEF,1,32'hDEADBEEF,0,0,1,0,0));
    vecs[3]  = mk(0,0,0,0,0,5,0,          ex(1,0,0,0,0,0,0,0,0,1,0));
    vecs[4]  = mk(0,1,0,32'h1234,0,0,0,   ex(1,0,0,0,0,0,0,0,0,1,0));
    vecs[5]  = mk(0,0,0,0,0,0,0,          ex(1,0,0,0,0,0,0,0,0,1,0));
    // Fill under hold, reject fifth push, then drain in order.
    vecs[6]  = mk(0,1,1,32'h10,1,0,0,     ex(1,0,0,0,0,0,0,0,0,1,0));
    vecs[7]  = mk(0,1,2,32'h20,1,0,0,     ex(1,0,1,32'h10,0,0,0,0,1,0,0));
    vecs[8]  = mk(0,1,3,32'h30,1,0,0,     ex(1,0,1,32'h10,0,0,0,0,2,0,0));
    vecs[9]  = mk(0,1,4,32'h40,1,0,0,     ex(1,0,1,32'h10,0,0,0,0,3,0,0));
    vecs[10] = mk(0,1,7,32'h70,1,4,7,     ex(0,0,1,32'h10,1,32'h40,0,0,4,0,1));
    vecs[11] = mk(0,0,0,0,0,1,0,          ex(0,1,1,32'h10,1,32'h10,0,0,4,0,1));
    vecs[12] = mk(0,0,0,0,0,1,0,          ex(1,1,2,32'h20,0,0,0,0,3,0,0));
    vecs[13] = mk(0,0,0,0,0,0,0,          ex(1,1,3,32'h30,0,0,0,0,2,0,0));
    vecs[14] = mk(0,0,0,0,0,0,7,          ex(1,1,4,32'h40,0,0,0,0,1,0,0));
    vecs[15] = mk(0,0,0,0,0,0,7,          ex(1,0,0,0,0,0,0,0,0,1,0));
    // Forwarding picks the youngest matching entry.
    vecs[16] = mk(0,1,3,32'hA,1,3,0,      ex(1,0,0,0,0,0,0,0,0,1,0));
    vecs[17] = mk(0,1,3,32'hB,1,3,0,      ex(1,0,3,32'hA,1,32'hA,0,0,1,0,0));
    vecs[18] = mk(0,1,9,32'hC,1,3,0,      ex(1,0,3,32'hA,1,32'hB,0,0,2,0,0));
    vecs[19] = mk(0,0,0,0,1,3,9,          ex(1,0,3,32'hA,1,32'hB,1,32'hC,3,0,0));
    vecs[20] = mk(0,0,0,0,1,3,4,          ex(1,0,3,32'hA,1,32'hB,0,0,3,0,0));
    // Reset with three entries pending discards them all.
    vecs[21] = mk(1,0,0,0,1,3,9,          ex(1,0,3,32'hA,1,32'hB,1,32'hC,3,0,0));
    vecs[22] = mk(0,0,0,0,0,3,9,          ex(1,0,0,0,0,0,0,0,0,1,0));

    rst = 1'b1; in_valid = 1'b0; in_rd = '0; in_data = '0; hold = 1'b0;
    q1_addr = '0; q2_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 23; i++) begin
      rst = vecs[i].rst; in_valid = vecs[i].v; in_rd = vecs[i].rd; in_data = vecs[i].d;
      hold = vecs[i].hold; q1_addr = vecs[i].a1; q2_addr = vecs[i].a2;
      #1;
      check($sformatf("row%0d", i), 128'(outs()), 128'(vecs[i].exp));
      @(posedge clk);
      #1;
    end
    rst = 1'b0;

    // Two more full fill/drain rounds exercise pointer wrap.
    for (int rep = 0; rep < 2; rep++) begin
      for (int r = 1; r <= 4; r++)
        cyc(1'b1, 5'(r), 32'(rep * 256 + r * 16), 1'b1);
      check("wrap_full", 128'(full), 128'(1));
      cyc(1'b1, 5'd7, 32'h70, 1'b1);
      for (int r = 0; r < 5; r++)
        cyc(1'b0, 5'd0, 32'h0, 1'b0);
    end

    // Steady-state push and pop each cycle with two entries resident.
    cyc(1'b1, 5'd10, 32'h100A, 1'b1);
    cyc(1'b1, 5'd11, 32'h100B, 1'b1);
    for (int k = 0; k < 6; k++)
      cyc(1'b1, 5'(12 + k), 32'(32'h2000 + k), 1'b0);
    for (int k = 0; k < 3; k++)
      cyc(1'b0, 5'd0, 32'h0, 1'b0);
    check("final_empty", 128'(empty), 128'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
